// File: rtl/core101_alu_pkg.sv
// Shared ALU micro-op encoding for the core101 execute stage.
// Used by the ALU, the issue arbiter and anything decoding uops.
package core101_alu_pkg;

  typedef logic [3:0] uop_t;

  localparam uop_t UOP_ADD   = 4'b0000;
  localparam uop_t UOP_SUB   = 4'b0001;
  localparam uop_t UOP_OR    = 4'b0010;
  localparam uop_t UOP_AND   = 4'b0011;
  localparam uop_t UOP_SLT   = 4'b0100;
  localparam uop_t UOP_SLTU  = 4'b0101;
  localparam uop_t UOP_SRA   = 4'b0110;
  localparam uop_t UOP_SRL   = 4'b0111;
  localparam uop_t UOP_BUF_A = 4'b1000;
  localparam uop_t UOP_BUF_B = 4'b1001;
  localparam uop_t UOP_SLL   = 4'b1010;

  function automatic logic uop_is_implemented(
    input uop_t uop
  );
    case (uop)
      UOP_ADD, UOP_SUB, UOP_OR, UOP_AND,
      UOP_BUF_A, UOP_BUF_B: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Generic valid/ready channel carrying a packed payload.
// master drives valid/data, slave drives ready.
interface alu_issue_arbiter_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/alu.sv
// Single-cycle shared execute ALU.
// Unimplemented uops return 0 and raise illegal.
module alu
  import core101_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  uop_t                  uop,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  always_comb begin
    result  = '0;
    illegal = !uop_is_implemented(uop);
    case (uop)
      UOP_ADD:   result = a + b;
      UOP_SUB:   result = a - b;
      UOP_OR:    result = a | b;
      UOP_AND:   result = a & b;
      UOP_BUF_A: result = a;
      UOP_BUF_B: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_fifo.sv
// Small circular result FIFO; push accepted only when not full,
// independent of a same-cycle pop. Head reads as 0 when empty.
module alu_result_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input logic          clock_in,
  input logic          reset_in,
  alu_issue_arbiter_if.slave  push,
  alu_issue_arbiter_if.master pop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_fire;
  logic             pop_fire;

  function automatic logic [PW-1:0] ptr_next(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push.ready = (count != CW'(DEPTH));
  assign pop.valid  = (count != '0);
  assign pop.data   = pop.valid ? mem[rd_ptr] : '0;

  assign push_fire = push.valid & push.ready;
  assign pop_fire  = pop.ready & pop.valid;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count + CW'(push_fire) - CW'(pop_fire);
      if (push_fire) wr_ptr <= ptr_next(wr_ptr);
      if (pop_fire)  rd_ptr <= ptr_next(rd_ptr);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock_in) begin
    if (push_fire) mem[wr_ptr] <= push.data;
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// EX-stage round-robin arbiter sharing one ALU between the
// integer pipe (port 0) and the branch/address unit (port 1).
module alu_issue_arbiter
  import core101_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  req0_valid_in,
  output logic                  req0_ready_out,
  input  logic [DATA_WIDTH-1:0] req0_a_in,
  input  logic [DATA_WIDTH-1:0] req0_b_in,
  input  logic [3:0]            req0_uop_in,
  input  logic [TAG_WIDTH-1:0]  req0_tag_in,
  input  logic                  req1_valid_in,
  output logic                  req1_ready_out,
  input  logic [DATA_WIDTH-1:0] req1_a_in,
  input  logic [DATA_WIDTH-1:0] req1_b_in,
  input  logic [3:0]            req1_uop_in,
  input  logic [TAG_WIDTH-1:0]  req1_tag_in,
  output logic                  res_valid_out,
  input  logic                  res_ready_in,
  output logic [DATA_WIDTH-1:0] res_data_out,
  output logic                  res_port_out,
  output logic [TAG_WIDTH-1:0]  res_tag_out,
  output logic                  res_illegal_out
);

  localparam int PW = DATA_WIDTH + TAG_WIDTH + 2;

  alu_issue_arbiter_if #(.W(PW)) push_if ();
  alu_issue_arbiter_if #(.W(PW)) pop_if ();

  logic                  last_grant;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  uop_t                  alu_uop;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_illegal;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      (req0_valid_in & req1_valid_in): begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end
      (req0_valid_in & ~req1_valid_in): grant0 = 1'b1;
      (~req0_valid_in & req1_valid_in): grant1 = 1'b1;
      default: ;
    endcase
  end

  // Full FIFO blocks issue even when the head pops this cycle.
  assign accept         = push_if.ready & ~reset_in;
  assign req0_ready_out = grant0 & accept;
  assign req1_ready_out = grant1 & accept;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      last_grant <= 1'b1;
    end else if (req0_ready_out | req1_ready_out) begin
      last_grant <= req1_ready_out;
    end
  end

  assign alu_a   = grant1 ? req1_a_in   : req0_a_in;
  assign alu_b   = grant1 ? req1_b_in   : req0_b_in;
  assign alu_uop = grant1 ? req1_uop_in : req0_uop_in;
  assign sel_tag = grant1 ? req1_tag_in : req0_tag_in;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a       (alu_a),
    .b       (alu_b),
    .uop     (alu_uop),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign push_if.valid = req0_ready_out | req1_ready_out;
  assign push_if.data  = {alu_illegal, sel_tag,
                          req1_ready_out, alu_result};

  alu_result_fifo #(.WIDTH(PW), .DEPTH(2)) u_fifo (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .push     (push_if),
    .pop      (pop_if)
  );

  assign pop_if.ready  = res_ready_in;
  assign res_valid_out = pop_if.valid;
  assign {res_illegal_out, res_tag_out,
          res_port_out, res_data_out} = pop_if.data;

endmodule

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Shares the single-cycle `ALU` execute datapath between two requesters: port 0 is the integer pipeline and port 1 is the branch/address unit. Each port uses a valid/ready handshake. The block grants one operation per cycle by round-robin and drives the shared `ALU`. It captures each result, tagged with its originating port, in a 2-entry result FIFO drained by a valid/ready consumer. It sits in EX, between the issue logic and writeback.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width
- `TAG_WIDTH`, 4, requester-supplied tag width (e.g. destination register index)

Ports (clock and reset first):
- `clock_in`  input  1  single clock; all state updates on rising edge
- `reset_in`  input  1  asynchronous, active-high reset
- `req0_valid_in`  input  1  port 0 has an operation
- `req0_ready_out`  output  1  port 0 operation accepted this cycle
- `req0_a_in`, `req0_b_in`  input  DATA_WIDTH  port 0 operands
- `req0_uop_in`  input  4  port 0 micro-opcode
- `req0_tag_in`  input  TAG_WIDTH  port 0 tag
- `req1_*`  same set as port 0, for port 1
- `res_valid_out`  output  1  FIFO head is valid
- `res_ready_in`  input  1  consumer takes the head this cycle
- `res_data_out`  output  DATA_WIDTH  head result
- `res_port_out`  output  1  originating port of the head
- `res_tag_out`  output  TAG_WIDTH  tag of the head
- `res_illegal_out`  output  1  head uop not implemented; data is 0

## Operation
- Implemented uops: 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 1000 pass A, 1001 pass B. All other codes produce result 0 with `illegal`=1.
- Accept condition: FIFO count < 2. When count == 2, nothing is accepted, even if the head is popped in the same cycle.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the port not granted most recently wins.
  - The last-grant pointer updates only on a grant.
  - Reset value of the pointer is 1, so port 0 wins the first contention.
- `reqN_ready_out` = grant to N. It is combinational from the valids, the pointer and the count. It never depends on `res_ready_in`.
- Handshake rule: a transfer occurs when valid && ready. Requesters must hold their inputs stable while valid && !ready.
- On a grant, the granted operands and uop are muxed into the `ALU`. The result, port, tag and illegal flag are written into the FIFO at the FIFO tail on that edge.
- FIFO: 2 entries, read/write pointers of 1 bit each, 2-bit count.
  - Push and pop in the same cycle leave count unchanged.
  - Results leave in grant order.
- Output fields come from the head entry. They are all 0 when the FIFO is empty.

## Timing
- Latency: an operation accepted in cycle N is visible on `res_*` in cycle N+1 if the FIFO was empty. Otherwise it appears behind the older entries.
- Throughput: 1 op/cycle while the consumer keeps `res_ready_in`=1.
- Full case: with count == 2 and `res_ready_in`=1, the pop happens in that cycle and a grant becomes possible in the next cycle. Peak rate under full backpressure is therefore one op every 2 cycles.
- Pop with `res_valid_out`=0 is ignored. Count never underflows or exceeds 2.
- Pointer wrap-around: the 1-bit pointers toggle 1→0 naturally.
- Reset (asynchronous, any time, including mid-stream):
  - count=0, pointers=0, last-grant=1.
  - All `res_*` outputs 0 and both `reqN_ready_out`=0 while `reset_in` is high.
  - In-flight FIFO contents are discarded.
  - First grant is possible in the first cycle after deassertion.

## Structure
- Shared package `core101_alu_pkg`:
  - uop constants: `UOP_ADD`, `UOP_SUB`, `UOP_OR`, `UOP_AND`, `UOP_BUF_A`, `UOP_BUF_B`, `UOP_SLT`, `UOP_SLTU`, `UOP_SRA`, `UOP_SRL`, `UOP_SLL`
  - `uop_is_implemented` helper
  - The `ALU` uses the same constants.
- Sub-modules:
  - The existing `ALU` is instantiated once.
  - The result FIFO is a natural sub-module, `alu_result_fifo`, with parameters for width and depth 2.
  - The arbiter stays inline.

## Test plan
- Single op, empty FIFO: port 0 ADD with a=5, b=7, tag=3. Expect `req0_ready_out`=1 in cycle N, then in N+1 `res_valid`=1, data=12, port=0, tag=3, illegal=0.
- Contention: both ports valid every cycle, consumer always ready. Expect grants 0,1,0,1…; port 1 SUB 10-3 returns 7; results appear in grant order.
- Backpressure: `res_ready_in`=0 with port 0 streaming.
  - Expect 2 accepts, then `req0_ready_out`=0 held.
  - Raise `res_ready_in` for 1 cycle: head pops, and one new accept occurs in the next cycle.
- Illegal uop: port 1 uop=0100, a=1, b=1. Expect data=0, illegal=1, port=1.
- Simultaneous push/pop at count=1: count stays 1, and the data order is preserved.
- Reset mid-stream: assert `reset_in` asynchronously with FIFO count=2. Expect `res_valid_out`=0 immediately, and port 0 wins the first contention after release.
